// File: rtl/netlist_seq_pkg.sv
// Shared types and defaults for the HelloWorld netlist stimulus sequencer.
package netlist_seq_pkg;

  localparam int IN_W_DEF  = 3;
  localparam int OUT_W_DEF = 16;
  localparam int ERR_W     = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

endpackage

// File: rtl/netlist_seq_vector_mem.sv
// Vector table: one synchronous write port, one asynchronous read port.
module netlist_seq_vector_mem
  import netlist_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = IN_W_DEF + 2 * OUT_W_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset; the host programs them before a run.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/netlist_stimulus_sequencer.sv
// Applies a programmed table of input vectors to the HelloWorld netlist and
// checks its FINAL_OUTPUT pins against masked expected values.
module netlist_stimulus_sequencer
  import netlist_seq_pkg::*;
#(
  parameter int IN_W          = IN_W_DEF,
  parameter int OUT_W         = OUT_W_DEF,
  parameter int DEPTH         = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int RESET_CYCLES  = 2
) (
  input  logic                     bertaClock,
  input  logic                     global_reset,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [IN_W-1:0]          cfg_stim,
  input  logic [OUT_W-1:0]         cfg_exp,
  input  logic [OUT_W-1:0]         cfg_mask,
  input  logic [$clog2(DEPTH):0]   num_vectors,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     dut_reset,
  output logic [IN_W-1:0]          dut_in,
  input  logic [OUT_W-1:0]         dut_out,
  output logic [ERR_W-1:0]         err_count,
  output logic [$clog2(DEPTH)-1:0] first_err_idx,
  output logic [OUT_W-1:0]         first_err_data
);

  localparam int AW      = $clog2(DEPTH);
  localparam int NW      = AW + 1;
  localparam int ENT_W   = IN_W + 2 * OUT_W;
  localparam int CNT_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [NW-1:0]      n_q, n_d;
  logic [IN_W-1:0]    dut_in_q, dut_in_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [AW-1:0]      fidx_q, fidx_d;
  logic [OUT_W-1:0]   fdata_q, fdata_d;
  logic               pass_q, pass_d;

  logic [ENT_W-1:0]   entry;
  logic [IN_W-1:0]    stim_rd;
  logic [OUT_W-1:0]   exp_rd, mask_rd;
  logic [NW-1:0]      n_start;
  logic               last_vec;
  logic               mismatch;

  netlist_seq_vector_mem #(.DEPTH(DEPTH), .W(ENT_W)) u_mem (
    .clk   (bertaClock),
    .we    (cfg_we && (state_q == IDLE)),
    .waddr (cfg_addr),
    .wdata ({cfg_stim, cfg_exp, cfg_mask}),
    .raddr (idx_q),
    .rdata (entry)
  );

  assign stim_rd  = entry[ENT_W-1 -: IN_W];
  assign exp_rd   = entry[2*OUT_W-1 -: OUT_W];
  assign mask_rd  = entry[OUT_W-1:0];
  assign n_start  = (num_vectors > NW'(DEPTH)) ? NW'(DEPTH) : num_vectors;
  assign last_vec = ({1'b0, idx_q} == (n_q - NW'(1)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    n_d      = n_q;
    dut_in_d = dut_in_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    fdata_d  = fdata_q;
    pass_d   = pass_q;
    mismatch = |((dut_out ^ exp_rd) & mask_rd);
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d      = n_start;
          idx_d    = '0;
          err_d    = '0;
          fidx_d   = '0;
          fdata_d  = '0;
          pass_d   = 1'b0;
          dut_in_d = '0;
          cnt_d    = RST_LOAD;
          state_d  = RST;
        end
      end
      RST: begin
        if (cnt_q == '0) state_d = (n_q == '0) ? DONE : APPLY;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      APPLY: begin
        dut_in_d = stim_rd;
        cnt_d    = SETTLE_LOAD;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      SAMPLE: begin
        // err_q is zero only before the first mismatch because it saturates, never wraps.
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
          if (err_q == '0) begin
            fidx_d  = idx_q;
            fdata_d = dut_out;
          end
        end
        if (last_vec) state_d = DONE;
        else begin
          idx_d   = idx_q + AW'(1);
          state_d = APPLY;
        end
      end
      DONE: begin
        pass_d  = (err_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort discards whatever this cycle would have recorded, including a SAMPLE result.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      dut_in_d = '0;
      pass_d   = 1'b0;
      idx_d    = idx_q;
      err_d    = err_q;
      fidx_d   = fidx_q;
      fdata_d  = fdata_q;
    end
  end

  always_ff @(posedge bertaClock or negedge global_reset) begin
    if (!global_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      n_q      <= '0;
      dut_in_q <= '0;
      err_q    <= '0;
      fidx_q   <= '0;
      fdata_q  <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      dut_in_q <= dut_in_d;
      err_q    <= err_d;
      fidx_q   <= fidx_d;
      fdata_q  <= fdata_d;
      pass_q   <= pass_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE) && !abort;
  assign dut_reset      = (state_q == RST);
  assign dut_in         = dut_in_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_idx  = fidx_q;
  assign first_err_data = fdata_q;

endmodule
